// File: rtl/tick_gen_if.sv
// Channel configuration, trigger and tick bus for tick_gen.
// The master drives the controls; the slave (tick_gen) returns ticks, busy flags and counters.
interface tick_gen_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0]       en;
    logic                      cfg_we;
    logic [CH_W-1:0]           cfg_ch;
    logic [WIDTH-1:0]          cfg_div;
    logic                      cfg_oneshot;
    logic [CHANNELS-1:0]       start;
    logic                      sync;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*WIDTH-1:0] cnt_dbg;

    modport master (
        output en, cfg_we, cfg_ch, cfg_div, cfg_oneshot, start, sync,
        input  tick, busy, cnt_dbg
    );

    modport slave (
        input  en, cfg_we, cfg_ch, cfg_div, cfg_oneshot, start, sync,
        output tick, busy, cnt_dbg
    );
endinterface

// File: rtl/tick_gen.sv
// Multi-channel programmable clock divider.
// Each channel emits a one-cycle tick either periodically or as a triggered one-shot.
module tick_gen #(
    parameter int               CHANNELS    = 4,
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = 16'd50000,
    parameter int               CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input logic        clk,
    input logic        rst,
    tick_gen_if.slave  bus
);

    // A divide of 0 behaves as a divide of 1.
    function automatic logic [WIDTH-1:0] term_of(input logic [WIDTH-1:0] div);
        return (div == '0) ? '0 : div - 1'b1;
    endfunction

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] div_p0;
        logic             mode_p0;
        logic [WIDTH-1:0] cnt_p0;
        logic             tick_p0;
        logic             busy_p0;
        logic             cfg_hit;
        logic             at_term;

        assign cfg_hit = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
        // ">=" so that lowering div below the running count terminates at once.
        assign at_term = (cnt_p0 >= term_of(div_p0));

        always_ff @(posedge clk) begin
            if (rst) begin
                div_p0  <= DEFAULT_DIV;
                mode_p0 <= 1'b0;
                cnt_p0  <= '0;
                tick_p0 <= 1'b0;
                busy_p0 <= 1'b0;
            end else if (cfg_hit) begin
                div_p0  <= bus.cfg_div;
                mode_p0 <= bus.cfg_oneshot;
                cnt_p0  <= '0;
                tick_p0 <= 1'b0;
                busy_p0 <= 1'b0;
            end else if (!bus.en[i]) begin
                cnt_p0  <= '0;
                tick_p0 <= 1'b0;
                busy_p0 <= 1'b0;
            end else if (bus.sync) begin
                cnt_p0  <= '0;
                tick_p0 <= 1'b0;
            end else if (mode_p0 && !busy_p0) begin
                // One-shot idle: the start edge itself is not counted.
                cnt_p0  <= '0;
                tick_p0 <= 1'b0;
                busy_p0 <= bus.start[i];
            end else if (at_term) begin
                cnt_p0  <= '0;
                tick_p0 <= 1'b1;
                busy_p0 <= 1'b0;
            end else begin
                cnt_p0  <= cnt_p0 + 1'b1;
                tick_p0 <= 1'b0;
            end
        end

        assign bus.tick[i]                    = tick_p0;
        assign bus.busy[i]                    = busy_p0;
        assign bus.cnt_dbg[i*WIDTH +: WIDTH]  = cnt_p0;
    end

endmodule

// File: tb/tb_tick_gen.sv
// Randomized scoreboard bench for tick_gen against a per-channel behavioural model.
module tb_tick_gen;
    localparam int CHANNELS = 4;
    localparam int WIDTH    = 16;
    localparam int CH_W     = 3;
    localparam int DEF_DIV  = 50000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tick_gen_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CH_W(CH_W)) bus ();

    tick_gen #(
        .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEFAULT_DIV(16'd50000), .CH_W(CH_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [CHANNELS-1:0]       tick;
        logic [CHANNELS-1:0]       busy;
        logic [CHANNELS*WIDTH-1:0] cnt;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Stimulus values applied at the next rising edge.
    logic                d_rst   = 1'b1;
    logic [CHANNELS-1:0] d_en    = '0;
    logic                d_we    = 1'b0;
    logic [CH_W-1:0]     d_ch    = '0;
    logic [WIDTH-1:0]    d_div   = '0;
    logic                d_os    = 1'b0;
    logic [CHANNELS-1:0] d_start = '0;
    logic                d_sync  = 1'b0;

    // Behavioural model: one record per channel in plain integers.
    int m_div  [CHANNELS];
    int m_cnt  [CHANNELS];
    bit m_os   [CHANNELS];
    bit m_tick [CHANNELS];
    bit m_busy [CHANNELS];

    function automatic void model_step();
        for (int i = 0; i < CHANNELS; i++) begin
            int period;
            period = (m_div[i] < 1) ? 1 : m_div[i];
            if (d_rst) begin
                m_div[i] = DEF_DIV; m_os[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_busy[i] = 0;
            end else if (d_we && int'(d_ch) == i) begin
                m_div[i] = int'(d_div); m_os[i] = d_os; m_cnt[i] = 0; m_tick[i] = 0; m_busy[i] = 0;
            end else if (!d_en[i]) begin
                m_cnt[i] = 0; m_tick[i] = 0; m_busy[i] = 0;
            end else if (d_sync) begin
                m_cnt[i] = 0; m_tick[i] = 0;
            end else if (m_os[i] && !m_busy[i]) begin
                m_cnt[i] = 0; m_tick[i] = 0;
                if (d_start[i]) m_busy[i] = 1;
            end else if (m_cnt[i] + 1 >= period) begin
                m_cnt[i] = 0; m_tick[i] = 1; m_busy[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1; m_tick[i] = 0;
            end
        end
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        for (int i = 0; i < CHANNELS; i++) begin
            e.tick[i] = m_tick[i];
            e.busy[i] = m_busy[i];
            e.cnt[i*WIDTH +: WIDTH] = WIDTH'(m_cnt[i]);
        end
        return e;
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst             = d_rst;
            bus.en          = d_en;
            bus.cfg_we      = d_we;
            bus.cfg_ch      = d_ch;
            bus.cfg_div     = d_div;
            bus.cfg_oneshot = d_os;
            bus.start       = d_start;
            bus.sync        = d_sync;
            model_step();
            q.push_back(model_out());
            d_we = 1'b0; d_start = '0; d_sync = 1'b0;
        end
    endtask

    task automatic cfg(input int ch, input int div, input bit os);
        d_we = 1'b1; d_ch = CH_W'(ch); d_div = WIDTH'(div); d_os = os;
        run(1);
    endtask

    // Monitor: compare every registered output one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.tick !== e.tick) begin
                    failures++;
                    $display("FAIL tick t=%0t got=%b want=%b", $time, bus.tick, e.tick);
                end
                checks++;
                if (bus.busy !== e.busy) begin
                    failures++;
                    $display("FAIL busy t=%0t got=%b want=%b", $time, bus.busy, e.busy);
                end
                checks++;
                if (bus.cnt_dbg !== e.cnt) begin
                    failures++;
                    $display("FAIL cnt_dbg t=%0t got=%h want=%h", $time, bus.cnt_dbg, e.cnt);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tick0_seen;
        d_rst = 1'b1;
        run(3);
        d_rst = 1'b0;

        // Default divide on channel 0 only; count its ticks independently of the model.
        d_en = 4'b0001;
        tick0_seen = 0;
        for (int k = 0; k < 50010; k++) begin
            run(1);
            @(posedge clk); #2;
            if (bus.tick[0]) tick0_seen++;
        end
        checks++;
        if (tick0_seen != 1) begin
            failures++;
            $display("FAIL default_div_ticks got=%0d want=1", tick0_seen);
        end

        // Periodic ch2: div 5, then 0, then 3 mid-count.
        d_en = 4'b0101;
        cfg(2, 5, 0); run(17);
        cfg(2, 0, 0); run(6);
        run(2); cfg(2, 3, 0); run(9);

        // One-shot ch1 div 4: start, retrigger attempt mid-run, restart after completion.
        d_en = 4'b0111;
        cfg(1, 4, 1); run(2);
        d_start = 4'b0010; run(2);
        d_start = 4'b0010; run(5);
        d_start = 4'b0010; run(6);
        // Start held high continuously: terminal-edge start must be ignored.
        for (int k = 0; k < 12; k++) begin d_start = 4'b0010; run(1); end

        // One-shot ch3 div 6: abort via en, then sync mid-run.
        d_en = 4'b1111;
        cfg(3, 6, 1); run(1);
        d_start = 4'b1000; run(3);
        d_en = 4'b0111; run(2);
        d_en = 4'b1111; run(2);
        d_start = 4'b1000; run(3);
        d_sync = 1'b1; run(9);

        // Periodic ch0/ch2 with different phases, then sync.
        cfg(0, 7, 0); run(3);
        cfg(2, 5, 0); run(4);
        d_sync = 1'b1; run(16);

        // Out-of-range channel write, then write to a disabled channel.
        cfg(5, 2, 1); run(8);
        d_en = 4'b1110; cfg(0, 3, 0); run(6);
        d_en = 4'b1111; run(8);

        // Randomized traffic.
        for (int k = 0; k < 6000; k++) begin
            d_rst = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 39) == 0) begin
                d_we  = 1'b1;
                d_ch  = CH_W'($urandom_range(0, 7));
                d_div = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(10, 40))
                                                    : WIDTH'($urandom_range(0, 9));
                d_os  = $urandom_range(0, 1);
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if ($urandom_range(0, 29) == 0) d_en[i] = ~d_en[i];
                d_start[i] = ($urandom_range(0, 7) == 0);
            end
            d_sync = ($urandom_range(0, 59) == 0);
            run(1);
        end
        d_rst = 1'b0;
        run(2);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
